tree_lane_dispatcher: RTL and testbench

- Front-end scheduler for the dual-lane bit-tree lookup pipeline.
- Buffers a single incoming header stream and issues up to two headers per cycle onto lane 1 and lane 2, each tagged with the root node and matched=0.
- Sequences node-memory update windows: on a config request it stops issuing, drains the pipeline for PIPE_DEPTH cycles, then grants exclusive write access until the updater signals done.

---
 rtl/tree_lane_dispatcher_if.sv | 43 ++++
 rtl/tree_lane_dispatcher.sv | 126 ++++++++++++
 tb/tb_tree_lane_dispatcher.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_lane_dispatcher_if.sv
// Header stream, dual-lane issue and node-memory config handshake
// of the bit-tree lookup front end.
interface tree_lane_dispatcher_if #(
    parameter int PACKET_WIDTH = 104,
    parameter int NODE_WIDTH   = 40
);
    // Handshake: a header moves on a clock edge where pkt_valid_in and
    // pkt_ready_out are both 1. The source holds pkt_in stable while valid
    // is high. pkt_ready_out never depends on pkt_valid_in.
    logic [PACKET_WIDTH-1:0] pkt_in;
    logic                    pkt_valid_in;
    logic                    pkt_ready_out;
    logic [NODE_WIDTH-1:0]   root_node;

    logic [PACKET_WIDTH-1:0] packet_out1;
    logic [NODE_WIDTH-1:0]   node_out1;
    logic                    matched_out1;
    logic                    data_valid_out1;
    logic [PACKET_WIDTH-1:0] packet_out2;
    logic [NODE_WIDTH-1:0]   node_out2;
    logic                    matched_out2;
    logic                    data_valid_out2;

    logic                    cfg_req;
    logic                    cfg_grant;
    logic                    cfg_done;

    modport master (
        output pkt_in, pkt_valid_in, root_node, cfg_req, cfg_done,
        input  pkt_ready_out,
        input  packet_out1, node_out1, matched_out1, data_valid_out1,
        input  packet_out2, node_out2, matched_out2, data_valid_out2,
        input  cfg_grant
    );

    modport slave (
        input  pkt_in, pkt_valid_in, root_node, cfg_req, cfg_done,
        output pkt_ready_out,
        output packet_out1, node_out1, matched_out1, data_valid_out1,
        output packet_out2, node_out2, matched_out2, data_valid_out2,
        output cfg_grant
    );
endinterface

// File: rtl/tree_lane_dispatcher.sv
// Buffers the header stream and issues up to two headers per cycle onto two
// lookup lanes; sequences drain/grant windows for node-memory updates.
module tree_lane_dispatcher #(
    parameter int PACKET_WIDTH = 104,
    parameter int NODE_WIDTH   = 40,
    parameter int FIFO_DEPTH   = 4,
    parameter int PIPE_DEPTH   = 12
) (
    input  logic                  clk,
    input  logic                  RST,
    tree_lane_dispatcher_if.slave bus,
    output logic [1:0]            state_dbg
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int DRAIN_W = $clog2(PIPE_DEPTH) + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t                  state;
    logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        rd_ptr_plus1;
    logic [CNT_W-1:0]        count;
    logic [DRAIN_W-1:0]      drain_cnt;
    logic                    push;
    logic                    issue_ok;
    logic [1:0]              pops;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign bus.pkt_ready_out = !RST && (count != CNT_W'(FIFO_DEPTH));
    assign push              = bus.pkt_valid_in && bus.pkt_ready_out;
    assign issue_ok          = (state == RUN) && !bus.cfg_req;
    assign rd_ptr_plus1      = rd_ptr + PTR_W'(1);
    assign state_dbg         = state;

    always_comb begin
        pops = 2'd0;
        if (issue_ok) begin
            if (count >= CNT_W'(2))
                pops = 2'd2;
            else if (count == CNT_W'(1))
                pops = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.pkt_in;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state               <= RUN;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            drain_cnt           <= '0;
            bus.cfg_grant       <= 1'b0;
            bus.packet_out1     <= '0;
            bus.node_out1       <= '0;
            bus.matched_out1    <= 1'b0;
            bus.data_valid_out1 <= 1'b0;
            bus.packet_out2     <= '0;
            bus.node_out2       <= '0;
            bus.matched_out2    <= 1'b0;
            bus.data_valid_out2 <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr + PTR_W'(pops);
            count  <= count + CNT_W'(push) - CNT_W'(pops);

            // Lanes default to all-zero; lane 1 always takes the older entry.
            bus.packet_out1     <= '0;
            bus.node_out1       <= '0;
            bus.matched_out1    <= 1'b0;
            bus.data_valid_out1 <= 1'b0;
            bus.packet_out2     <= '0;
            bus.node_out2       <= '0;
            bus.matched_out2    <= 1'b0;
            bus.data_valid_out2 <= 1'b0;
            if (pops != 2'd0) begin
                bus.packet_out1     <= mem[rd_ptr];
                bus.node_out1       <= bus.root_node;
                bus.data_valid_out1 <= 1'b1;
            end
            if (pops == 2'd2) begin
                bus.packet_out2     <= mem[rd_ptr_plus1];
                bus.node_out2       <= bus.root_node;
                bus.data_valid_out2 <= 1'b1;
            end

            case (state)
                RUN: begin
                    if (bus.cfg_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_W'(PIPE_DEPTH - 1);
                    end
                end
                DRAIN: begin
                    if (!bus.cfg_req) begin
                        state <= RUN;
                    end else if (drain_cnt == '0) begin
                        state         <= GRANT;
                        bus.cfg_grant <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                GRANT: begin
                    if (bus.cfg_done) begin
                        state         <= RUN;
                        bus.cfg_grant <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_tree_lane_dispatcher.sv
// Scoreboarded bench for tree_lane_dispatcher: lane order, pairing,
// drain/grant timing, abort, root_node sampling and reset during grant.
module tb_tree_lane_dispatcher;
    localparam int PW = 104;
    localparam int NW = 40;
    localparam int FD = 4;
    localparam int PD = 12;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [NW-1:0] NEW_ROOT = 40'h12_3456_789A;

    logic          clk = 1'b0;
    logic          RST;
    logic [1:0]    state_dbg;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] exp_q[$];
    logic [NW-1:0] root_val;

    tree_lane_dispatcher_if #(.PACKET_WIDTH(PW), .NODE_WIDTH(NW)) bus ();

    tree_lane_dispatcher #(
        .PACKET_WIDTH(PW), .NODE_WIDTH(NW), .FIFO_DEPTH(FD), .PIPE_DEPTH(PD)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    task automatic send(input logic [PW-1:0] d, output logic acc);
        bus.pkt_in       = d;
        bus.pkt_valid_in = 1'b1;
        acc              = bus.pkt_ready_out;
        tick();
        if (acc)
            exp_q.push_back(d);
        bus.pkt_valid_in = 1'b0;
        bus.pkt_in       = '0;
    endtask

    // scoreboard: every valid lane output pops the oldest expected header
    always @(negedge clk) begin
        logic [PW-1:0] e;
        if (!RST) begin
            if (bus.data_valid_out1) begin
                if (exp_q.size() == 0) begin
                    check("lane1_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("lane1_pkt", bus.packet_out1, e);
                end
                check("lane1_node", bus.node_out1, root_val);
                check("lane1_matched", bus.matched_out1, 0);
            end else begin
                check("lane1_idle_pkt", bus.packet_out1, 0);
                check("lane1_idle_node", {bus.node_out1, bus.matched_out1}, 0);
            end
            if (bus.data_valid_out2) begin
                check("lane2_without_lane1", bus.data_valid_out1, 1);
                if (exp_q.size() == 0) begin
                    check("lane2_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("lane2_pkt", bus.packet_out2, e);
                end
                check("lane2_node", bus.node_out2, root_val);
                check("lane2_matched", bus.matched_out2, 0);
            end else begin
                check("lane2_idle_pkt", bus.packet_out2, 0);
                check("lane2_idle_node", {bus.node_out2, bus.matched_out2}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic [PW-1:0] pa, pb, pc, px;

        RST              = 1'b1;
        bus.pkt_in       = '0;
        bus.pkt_valid_in = 1'b0;
        bus.cfg_req      = 1'b0;
        bus.cfg_done     = 1'b0;
        root_val         = 40'hA5_5A0F_F00F;
        bus.root_node    = root_val;
        repeat (2) tick();

        check("rst_ready", bus.pkt_ready_out, 0);
        check("rst_grant", bus.cfg_grant, 0);
        check("rst_v1", bus.data_valid_out1, 0);
        check("rst_v2", bus.data_valid_out2, 0);
        check("rst_state", state_dbg, S_RUN);
        RST = 1'b0;
        #1;
        check("ready_after_rst", bus.pkt_ready_out, 1);
        tick();

        // Headers buffered during an aborted drain, then issued as a pair plus a single
        pa = rand_pkt();
        pb = rand_pkt();
        pc = rand_pkt();
        bus.cfg_req = 1'b1;
        tick();
        check("abort_enter_drain", state_dbg, S_DRAIN);
        send(pa, acc);
        send(pb, acc);
        send(pc, acc);
        tick();
        tick();
        check("abort_no_issue", bus.data_valid_out1, 0);
        check("abort_no_grant", bus.cfg_grant, 0);
        bus.cfg_req = 1'b0;
        tick();
        check("abort_state_run", state_dbg, S_RUN);
        check("abort_grant_low", bus.cfg_grant, 0);
        check("abort_v1_first_run", bus.data_valid_out1, 0);
        tick();
        check("pair_v1", bus.data_valid_out1, 1);
        check("pair_v2", bus.data_valid_out2, 1);
        check("pair_lane1_a", bus.packet_out1, pa);
        check("pair_lane2_b", bus.packet_out2, pb);
        tick();
        check("single_v1", bus.data_valid_out1, 1);
        check("single_v2", bus.data_valid_out2, 0);
        check("single_lane1_c", bus.packet_out1, pc);
        tick();

        // Continuous stream: ready must never drop
        for (int i = 0; i < 50; i++) begin
            send(rand_pkt(), acc);
            check("stream_ready", acc, 1);
        end
        repeat (3) tick();
        check("stream_drained", exp_q.size(), 0);

        // cfg_done outside GRANT is ignored
        bus.cfg_done = 1'b1;
        tick();
        bus.cfg_done = 1'b0;
        check("done_in_run_state", state_dbg, S_RUN);
        check("done_in_run_grant", bus.cfg_grant, 0);
        send(rand_pkt(), acc);
        repeat (2) tick();

        // Full drain/grant window with the buffer filling behind it
        px = rand_pkt();
        send(px, acc);
        bus.cfg_req = 1'b1;
        tick();
        check("req_blocks_issue", bus.data_valid_out1, 0);
        check("req_state_drain", state_dbg, S_DRAIN);
        for (int i = 0; i < PD; i++) begin
            send(rand_pkt(), acc);
            check("fill_accept", acc, (i < FD - 1) ? 1 : 0);
            check("grant_timing", bus.cfg_grant, (i == PD - 1) ? 1 : 0);
        end
        check("grant_state", state_dbg, S_GRANT);
        check("full_ready_low", bus.pkt_ready_out, 0);
        bus.cfg_req = 1'b0;
        tick();
        check("grant_ignores_req", bus.cfg_grant, 1);
        root_val      = NEW_ROOT;
        bus.root_node = root_val;
        tick();
        bus.cfg_done = 1'b1;
        tick();
        bus.cfg_done = 1'b0;
        check("done_grant_low", bus.cfg_grant, 0);
        check("done_state_run", state_dbg, S_RUN);
        check("done_no_issue_yet", bus.data_valid_out1, 0);
        tick();
        check("post_grant_v1", bus.data_valid_out1, 1);
        check("post_grant_v2", bus.data_valid_out2, 1);
        check("post_grant_lane1_x", bus.packet_out1, px);
        check("post_grant_root", bus.node_out1, NEW_ROOT);
        tick();
        check("post_grant_pair2", bus.data_valid_out2, 1);
        repeat (2) tick();
        check("window_drained", exp_q.size(), 0);

        // Reset while granted with three headers buffered
        bus.cfg_req = 1'b1;
        tick();
        for (int i = 0; i < PD; i++) begin
            if (i < 3)
                send(rand_pkt(), acc);
            else
                tick();
        end
        bus.cfg_req = 1'b0;
        check("grant2_high", bus.cfg_grant, 1);
        RST = 1'b1;
        exp_q.delete();
        tick();
        check("rst_grant_low", bus.cfg_grant, 0);
        check("rst_mid_v1", bus.data_valid_out1, 0);
        check("rst_mid_v2", bus.data_valid_out2, 0);
        check("rst_mid_ready", bus.pkt_ready_out, 0);
        check("rst_mid_state", state_dbg, S_RUN);
        RST = 1'b0;
        #1;
        check("rst_mid_ready_after", bus.pkt_ready_out, 1);
        tick();
        check("rst_fifo_empty", bus.data_valid_out1, 0);
        repeat (2) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
